// File: rtl/display_scheduler_if.sv
// Message-source inputs and scan outputs of the 4-digit display scheduler.
// master drives the message sources, slave is the scheduler itself.
interface display_scheduler_if;
   logic [1:0] estado;
   logic [3:0] produto;
   logic [3:0] valor_moedas;
   logic       err_req;
   logic [3:0] err_id;
   logic [3:0] digit_code;
   logic [3:0] digit_sel;
   logic       frame_tick;
   logic [1:0] src;
   logic       err_busy;

   modport master (
      output estado, produto, valor_moedas, err_req, err_id,
      input  digit_code, digit_sel, frame_tick, src, err_busy
   );

   modport slave (
      input  estado, produto, valor_moedas, err_req, err_id,
      output digit_code, digit_sel, frame_tick, src, err_busy
   );
endinterface

// File: rtl/display_scheduler.sv
// Composes, commits at frame boundaries, and scans the 4-digit vending display.
// Optional macro BLINK_ERROR_EN blanks every odd error frame so the banner blinks.
//
// Error FSM states:
//   state  | meaning
//   S_IDLE | no error banner; frames follow estado
//   S_HOLD | error banner owns the display until the hold count expires
module display_scheduler #(
   parameter int SCAN_DIV = 50000,
   parameter int MSG_HOLD = 100
) (
   input  logic               clk,
   input  logic               rst_n,
   display_scheduler_if.slave bus
);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int HW = $clog2(MSG_HOLD + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [HW-1:0] HOLD_INIT  = HW'(MSG_HOLD);
   localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } err_state_t;

   err_state_t       state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [1:0]       slot_q, slot_d;
   logic [3:0]       sel_q, sel_d;
   logic [3:0][3:0]  fb_q, fb_d;
   logic [1:0]       src_q, src_d;
   logic [HW-1:0]    cnt_q, cnt_d;
   logic             shown_q, shown_d;
   logic [3:0]       eid_q, eid_d;

   logic             wrap;
   logic             frame_tick;
   logic             expire;
   logic             err_show;
   logic [3:0]       err_digit;
   logic [3:0][3:0]  msg;
   logic [1:0]       msg_src;
   logic [7:0]       pc_w;
   logic [11:0]      cc_w;

   function automatic logic [7:0] prod_code(input logic [3:0] p);
      case (p)
         4'b0100: prod_code = 8'h10;
         4'b0101: prod_code = 8'h11;
         4'b1000: prod_code = 8'h20;
         4'b1001: prod_code = 8'h21;
         4'b1010: prod_code = 8'h22;
         4'b1011: prod_code = 8'h23;
         4'b1100: prod_code = 8'h30;
         4'b1101: prod_code = 8'h31;
         default: prod_code = 8'h00;
      endcase
   endfunction

   // {int, f1, f2}; credit above 8 quarters saturates at 2.00
   function automatic logic [11:0] credit_code(input logic [3:0] v);
      logic [3:0] n;
      logic [7:0] f;
      n = (v > 4'd8) ? 4'd8 : v;
      case (n[1:0])
         2'd0:    f = 8'h00;
         2'd1:    f = 8'h25;
         2'd2:    f = 8'h50;
         default: f = 8'h75;
      endcase
      credit_code = {2'b00, n[3:2], f};
   endfunction

   assign pc_w = prod_code(bus.produto);
   assign cc_w = credit_code(bus.valor_moedas);

`ifdef BLINK_ERROR_EN
   logic blank_q, blank_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         presc_q <= '0;
         slot_q  <= 2'd0;
         sel_q   <= 4'b0001;
         fb_q    <= {4'h8, 4'h6, 4'h9, 4'h0};
         src_q   <= 2'd0;
         cnt_q   <= '0;
         shown_q <= 1'b0;
         eid_q   <= 4'h0;
`ifdef BLINK_ERROR_EN
         blank_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         slot_q  <= slot_d;
         sel_q   <= sel_d;
         fb_q    <= fb_d;
         src_q   <= src_d;
         cnt_q   <= cnt_d;
         shown_q <= shown_d;
         eid_q   <= eid_d;
`ifdef BLINK_ERROR_EN
         blank_q <= blank_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      slot_d    = slot_q;
      fb_d      = fb_q;
      src_d     = src_q;
      cnt_d     = cnt_q;
      shown_d   = shown_q;
      eid_d     = eid_q;
      msg       = {4'h8, 4'h6, 4'h9, 4'h0};
      msg_src   = 2'd0;
      expire    = 1'b0;

      wrap       = (presc_q == PRESC_LAST);
      presc_d    = wrap ? '0 : presc_q + PW'(1);
      slot_d     = wrap ? slot_q + 2'd1 : slot_q;
      frame_tick = wrap && (slot_q == 2'd3);
      sel_d      = 4'b0001 << slot_d;

      // The count only runs once the banner has really been committed, so
      // the hold spans exactly MSG_HOLD displayed frames.
      case (state_q)
         S_HOLD: begin
            if (frame_tick) begin
               if (shown_q) begin
                  cnt_d = cnt_q - HW'(1);
                  if (cnt_q == HOLD_ONE) begin
                     expire  = 1'b1;
                     state_d = S_IDLE;
                     shown_d = 1'b0;
                  end
               end else begin
                  shown_d = 1'b1;
               end
            end
         end
         default: ;
      endcase

      if (bus.err_req) begin
         state_d = S_HOLD;
         cnt_d   = HOLD_INIT;
         shown_d = frame_tick;
         eid_d   = bus.err_id;
      end

      err_show  = bus.err_req || ((state_q == S_HOLD) && !expire);
      err_digit = bus.err_req ? bus.err_id : eid_q;

      if (err_show) begin
         msg     = {err_digit, 4'h0, 4'h4, 4'h6};
         msg_src = 2'd3;
      end else begin
         case (bus.estado)
            2'b01: begin
               msg_src = 2'd1;
               if (bus.produto == 4'hF) begin
                  msg = {4'h4, 4'h0, 4'h4, 4'h6};
               end else begin
                  msg = {4'hF, 4'hF, pc_w[3:0], pc_w[7:4]};
               end
            end
            2'b10: begin
               if (bus.valor_moedas == 4'd0) begin
                  msg_src = 2'd1;
                  msg     = {4'hF, 4'hF, pc_w[3:0], pc_w[7:4]};
               end else begin
                  msg_src = 2'd2;
                  msg     = {cc_w[3:0], cc_w[7:4], 4'hA, cc_w[11:8]};
               end
            end
            default: ;
         endcase
      end

      if (frame_tick) begin
         fb_d  = msg;
         src_d = msg_src;
      end
   end

`ifdef BLINK_ERROR_EN
   // Parity restarts with the first error frame following a non-error frame.
   always_comb begin
      blank_d = blank_q;
      if (frame_tick) begin
         blank_d = (msg_src == 2'd3) && (src_q == 2'd3) && !blank_q;
      end
   end

   assign bus.digit_sel = blank_q ? 4'b0000 : sel_q;
`else
   assign bus.digit_sel = sel_q;
`endif

   assign bus.digit_code = fb_q[slot_q];
   assign bus.frame_tick = frame_tick;
   assign bus.src        = src_q;
   assign bus.err_busy   = (state_q == S_HOLD);

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler: a frame-level reference model pushes
// expected frames, a monitor rebuilds each scanned frame and compares it.
module tb_display_scheduler;
   localparam int SD    = 4;
   localparam int MH    = 3;
   localparam int FRAME = 4 * SD;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   display_scheduler_if bus ();

   display_scheduler #(.SCAN_DIV(SD), .MSG_HOLD(MH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] digits;
      logic [1:0]  src;
      int          end_cyc;
      bit          blank;
   } frame_t;

   frame_t exp_q[$];
   int     n_checks = 0;
   int     n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
   endtask

   // Frame digits packed L1..L4 from MSB to LSB.
   function automatic logic [15:0] model_msg(input logic [1:0] e, input logic [3:0] p,
                                             input logic [3:0] v, output logic [1:0] s);
      int num;
      int n;
      int cents;
      s = 2'd0;
      if (e == 2'b01 && p == 4'hF) begin
         s = 2'd1;
         return 16'h6404;
      end
      if (e == 2'b01 || (e == 2'b10 && v == 4'd0)) begin
         s = 2'd1;
         case (p)
            4'd4:    num = 10;
            4'd5:    num = 11;
            4'd8:    num = 20;
            4'd9:    num = 21;
            4'd10:   num = 22;
            4'd11:   num = 23;
            4'd12:   num = 30;
            4'd13:   num = 31;
            default: num = 0;
         endcase
         return {4'(num / 10), 4'(num % 10), 8'hFF};
      end
      if (e == 2'b10) begin
         s     = 2'd2;
         n     = (v > 4'd8) ? 8 : int'(v);
         cents = n * 25;
         return {4'(cents / 100), 4'hA, 4'((cents % 100) / 10), 4'(cents % 10)};
      end
      return 16'h0968;
   endfunction

   int          k;
   int          err_left;
   int          err_run;
   logic [3:0]  err_id_m;
   bit          show_err;
   bit          busy_m;
   frame_t      f_m;
   logic [1:0]  s_m;

   // Reference model: counts error frames still owed rather than tracking an FSM.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k        = 0;
         err_left = 0;
         err_run  = 0;
         show_err = 1'b0;
         busy_m   = 1'b0;
         exp_q.delete();
         f_m.digits  = 16'h0968;
         f_m.src     = 2'd0;
         f_m.end_cyc = FRAME - 1;
         f_m.blank   = 1'b0;
         exp_q.push_back(f_m);
      end else begin
         if (bus.err_req) begin
            err_id_m = bus.err_id;
            err_left = MH;
         end
         if (k % FRAME == FRAME - 1) begin
            if (err_left > 0) begin
               f_m.digits = {12'h640, err_id_m};
               f_m.src    = 2'd3;
`ifdef BLINK_ERROR_EN
               f_m.blank  = (err_run % 2) == 1;
`else
               f_m.blank  = 1'b0;
`endif
               err_left--;
               err_run++;
            end else begin
               f_m.digits = model_msg(bus.estado, bus.produto, bus.valor_moedas, s_m);
               f_m.src    = s_m;
               f_m.blank  = 1'b0;
               err_run    = 0;
            end
            f_m.end_cyc = k + FRAME;
            show_err    = (f_m.src == 2'd3);
            exp_q.push_back(f_m);
         end
         busy_m = (err_left > 0) || show_err;
         k++;
      end
   end

   logic [15:0] obs;
   logic [3:0]  seen;
   int          frames_done = 0;
   frame_t      f_c;

   always @(negedge clk) begin
      if (!rst_n) begin
         obs  = 16'h0;
         seen = 4'h0;
      end else begin
         for (int p = 0; p < 4; p++) begin
            if (bus.digit_sel == (4'b0001 << p)) obs[15 - 4*p -: 4] = bus.digit_code;
         end
         seen = seen | bus.digit_sel;
         check("err_busy", 32'(bus.err_busy), 32'(busy_m));
         if (bus.frame_tick) begin
            if (exp_q.size() == 0) begin
               check("frame_queue_empty", 32'd0, 32'd1);
            end else begin
               f_c = exp_q.pop_front();
               check("tick_cycle", 32'(k), 32'(f_c.end_cyc));
               check("src", 32'(bus.src), 32'(f_c.src));
               if (f_c.blank) begin
                  check("blank_sel", 32'(seen), 32'd0);
               end else begin
                  check("sel_seen", 32'(seen), 32'hF);
                  check("digits", 32'(obs), 32'(f_c.digits));
               end
               frames_done++;
            end
            obs  = 16'h0;
            seen = 4'h0;
         end
      end
   end

   task automatic reset_checks();
      check("rst_digit_sel", 32'(bus.digit_sel), 32'h1);
      check("rst_digit_code", 32'(bus.digit_code), 32'h0);
      check("rst_src", 32'(bus.src), 32'h0);
      check("rst_err_busy", 32'(bus.err_busy), 32'h0);
      check("rst_frame_tick", 32'(bus.frame_tick), 32'h0);
   endtask

   task automatic set_in(input logic [1:0] e, input logic [3:0] p, input logic [3:0] v);
      @(negedge clk);
      bus.estado       = e;
      bus.produto      = p;
      bus.valor_moedas = v;
   endtask

   task automatic pulse_err(input logic [3:0] id);
      @(negedge clk);
      bus.err_req = 1'b1;
      bus.err_id  = id;
      @(negedge clk);
      bus.err_req = 1'b0;
   endtask

   task automatic run_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.estado       = 2'b00;
      bus.produto      = 4'h0;
      bus.valor_moedas = 4'h0;
      bus.err_req      = 1'b0;
      bus.err_id       = 4'h0;
      repeat (2) @(negedge clk);
      reset_checks();
      @(negedge clk);
      #2 rst_n = 1'b1;

      run_cycles(2 * FRAME);
      set_in(2'b01, 4'b1011, 4'd0);
      run_cycles(2 * FRAME);
      set_in(2'b01, 4'hF, 4'd0);
      run_cycles(2 * FRAME);
      set_in(2'b10, 4'b0101, 4'd0);
      run_cycles(FRAME + SD);
      set_in(2'b10, 4'b0101, 4'd7);
      run_cycles(2 * FRAME);
      set_in(2'b10, 4'b0101, 4'd12);
      run_cycles(2 * FRAME);

      pulse_err(4'd5);
      run_cycles(5 * FRAME);

      pulse_err(4'd9);
      run_cycles(FRAME + FRAME / 2);
      pulse_err(4'd4);
      run_cycles(5 * FRAME);

      // error request landing exactly on the commit cycle
      for (int i = 0; i < FRAME + 1; i++) begin
         @(negedge clk);
         if (k % FRAME == FRAME - 1) break;
      end
      bus.err_req = 1'b1;
      bus.err_id  = 4'd2;
      @(negedge clk);
      bus.err_req = 1'b0;
      run_cycles(FRAME);

      // new request coinciding with the expiry of the running hold
      for (int i = 0; i < 6 * FRAME; i++) begin
         @(negedge clk);
         if (err_left == 0 && show_err && (k % FRAME == FRAME - 1)) break;
      end
      bus.err_req = 1'b1;
      bus.err_id  = 4'd3;
      @(negedge clk);
      bus.err_req = 1'b0;
      run_cycles(5 * FRAME);

      for (int i = 0; i < 150; i++) begin
         run_cycles($urandom_range(1, 12));
         bus.estado       = 2'($urandom_range(0, 3));
         bus.produto      = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(8, 13))
                                                        : 4'($urandom_range(0, 15));
         bus.valor_moedas = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 4) == 0) begin
            bus.err_req = 1'b1;
            bus.err_id  = 4'($urandom_range(0, 15));
            @(negedge clk);
            bus.err_req = 1'b0;
         end
      end
      run_cycles(5 * FRAME);

      pulse_err(4'd7);
      run_cycles(FRAME + 5);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 reset_checks();
      run_cycles(3);
      #2 rst_n = 1'b1;
      bus.estado = 2'b00;
      run_cycles(3 * FRAME);

      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         if (k % FRAME == 2) break;
      end
      check("queue_depth", 32'(exp_q.size()), 32'd1);
      check("frames_seen", 32'(frames_done >= 80), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
Sequences and shares the 4-digit multiplexed 7-segment display between the vending machine's message sources: idle banner, product code, credit value and timed error banners. It composes a 4-nibble frame and commits it to a tear-free frame buffer only at frame boundaries. It then scans the buffer digit by digit. Its outputs drive the existing nibble-to-segment decoder and the digit enables D1..D4.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot (legal range >= 2)
MSG_HOLD, 100, number of full scan frames an error banner stays displayed (legal range >= 1)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
estado  input  2  main FSM state: 00 wait, 01 product, 10 compare, 11 treated as wait
produto  input  4  selected product code; 4'hF = invalid selection
valor_moedas  input  4  inserted credit in quarters, 0..8
err_req  input  1  one-cycle pulse requesting an error banner
err_id  input  4  last digit of error banner (E,4,0,err_id); sampled when err_req=1
digit_code  output  4  nibble for the 7-segment decoder (current slot)
digit_sel  output  4  one-hot active-high digit enable, bit0=D1 .. bit3=D4
frame_tick  output  1  one-cycle pulse when slot 3 ends
src  output  2  committed source: 0 idle, 1 product, 2 credit, 3 error
err_busy  output  1  high from the cycle after err_req until the error hold expires

Behaviour:
- Reset values: prescaler=0, slot=0, frame buffer={0,9,6,8} ("OPEn"), digit_sel=4'b0001, digit_code=4'h0, src=0, err_busy=0, frame_tick=0, hold counter=0.
- Prescaler counts 0..SCAN_DIV-1. On wrap, slot advances 0,1,2,3,0.
- frame_tick is asserted in the cycle the slot goes 3->0.
- digit_sel is the registered one-hot decode of slot. digit_code is frame_buffer[slot]: L1 at slot 0 through L4 at slot 3.
- Composition (combinational) selects the message by priority:
  - ERROR if the error hold is active: {6,4,0,err_id_latched}.
  - estado=01: produto=F gives {6,4,0,4}, not held. Otherwise gives the product code {c1,c2,F,F}.
  - estado=10: valor_moedas=0 gives the product code. Otherwise gives the credit {int,A,f1,f2}.
  - estado=00/11: {0,9,6,8}.
- Product code map (c1c2): 0000->00, 0100->10, 0101->11, 1000->20, 1001->21, 1010->22, 1011->23, 1100->30, 1101->31, any other value->00. Nibble F = blank.
- Credit map: n=valor_moedas, saturated to 8 if greater than 8. int=n>>2. n[1:0] selects f1f2: 0->00, 1->25, 2->50, 3->75. Nibble A = decimal point.
- Frame commit: the frame buffer and src load the composed message only in the frame_tick cycle. Input changes become visible at the next frame boundary, with worst-case latency of 4*SCAN_DIV cycles.
- Error FSM, states IDLE and HOLD:
  - err_req in any state: latch err_id, set err_busy next cycle, arm the hold counter to MSG_HOLD, enter HOLD.
  - The counter decrements on each frame_tick after the first committed error frame.
  - When it reaches 0: return to IDLE and clear err_busy. The next frame commit shows the estado-derived message.
  - err_req during HOLD restarts the counter and replaces the id.
  - err_req coincident with expiry: the restart wins.
  - err_req in the same cycle as frame_tick: the error is committed in that frame.
- rst_n asserted mid-frame or mid-hold: all state returns immediately to reset values and any pending error is discarded.

Optional Feature:
BLINK_ERROR_EN: when defined, while src=3, digit_sel is forced to 4'b0000 on every odd frame counted from the first error frame, so the banner blinks at half the frame rate. digit_code is unaffected. When undefined, the error banner is steady. All other behaviour is identical in both builds.

Test Plan:
- Reset with SCAN_DIV=4, MSG_HOLD=3, estado=00 -> digit_sel cycles 0001,0010,0100,1000 every 4 clks; digit_code 0,9,6,8; frame_tick every 16 clks; src=0.
- estado=01, produto=1011 -> after the next frame_tick, digits 2,3,F,F and src=1. Then produto=F -> next frame shows 6,4,0,4 with err_busy=0.
- estado=10, valor_moedas 0->7 mid-frame -> the current frame is unchanged; the next frame shows 1,A,7,5 and src=2. valor_moedas=12 -> 2,A,0,0.
- err_req with err_id=5 in estado=10 -> err_busy=1 next clk; the next frame shows 6,4,0,5 and src=3. It stays for exactly 3 frames, then the credit message returns and err_busy=0.
- A second err_req with err_id=4 during the 2nd hold frame -> the banner switches to 6,4,0,4 at the next frame and the hold restarts for 3 frames.
- rst_n low during HOLD -> immediate return to reset values. With BLINK_ERROR_EN defined, error frames alternate between digit_sel active and 0000.
